// File: rtl/serial_pkg.sv
// Shared definitions for the serial link receive end: word-size defaults and FSM encoding.
package serial_pkg;
  localparam int         BITS_DEF      = 8;
  localparam logic [7:0] IDLE_FILL_DEF = 8'hFF;

  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;
endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizer chain for one asynchronous pin, with registered rise/fall pulses.
// FILTER=1 adds a 2-sample agreement filter on the synchronized value (+1 clk latency,
// single-clk pulses never reach the edge compare).
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2,
  parameter bit RST_VAL     = 1'b0,
  parameter bit FILTER      = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   cur, prev_q;

  // metastability chain, idles at the pin's inactive level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= {SYNC_STAGES{RST_VAL}};
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  generate
    if (FILTER) begin : g_filt
      logic filt_q;
      // follow the synced value only once the last two chain stages agree
      always_ff @(posedge clk or posedge reset) begin
        if (reset) filt_q <= RST_VAL;
        else if (sync_q[SYNC_STAGES-1] == sync_q[SYNC_STAGES-2]) filt_q <= sync_q[SYNC_STAGES-1];
      end
      assign cur = filt_q;
    end else begin : g_raw
      assign cur = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // registered edge compare against the previous sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= RST_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      prev_q <= cur;
      rise   <= cur & ~prev_q;
      fall   <= ~cur & prev_q;
    end
  end
endmodule

// File: rtl/serial_shift_responder.sv
// Serial link receive end (mode 0, MSB first): synchronizes sclk/cs_n/mosi into clk,
// shifts in BITS-bit words on sclk rise and shifts a buffered response out on sclk fall.
// Build option: define SCLK_FILTER_EN to put a 2-sample glitch filter on synchronized sclk.
module serial_shift_responder
  import serial_pkg::*;
#(
  parameter int              SYNC_STAGES = 2,
  parameter int              BITS        = BITS_DEF,
  parameter logic [BITS-1:0] IDLE_FILL   = BITS'(IDLE_FILL_DEF)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sclk_in,
  input  logic            cs_n,
  input  logic            mosi,
  output logic            miso,
  input  logic [BITS-1:0] tx_data,
  input  logic            tx_load,
  output logic            tx_ready,
  output logic [BITS-1:0] rx_data,
  output logic            rx_valid,
  output logic            sclk_pos_edge,
  output logic            sclk_neg_edge
);
  localparam int CW = $clog2(BITS);

`ifdef SCLK_FILTER_EN
  localparam bit SCLK_FILT = 1'b1;
`else
  localparam bit SCLK_FILT = 1'b0;
`endif

  state_t                 state_q, state_d;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   mosi_s;
  logic [BITS-1:0]        rx_shift, tx_shift, txbuf, tx_next;
  logic                   txfull, reload_pend, consume;
  logic [CW-1:0]          bit_cnt;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0), .FILTER(SCLK_FILT)) u_sclk (
    .clk(clk), .reset(reset), .din(sclk_in), .rise(sclk_rise), .fall(sclk_fall));

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1), .FILTER(1'b0)) u_cs (
    .clk(clk), .reset(reset), .din(cs_n), .rise(cs_rise), .fall(cs_fall));

  // mosi gets the same chain length so data is settled when the sclk edge arrives
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mosi_q <= '0;
    else       mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s  = mosi_q[SYNC_STAGES-1];

  // word handed to the shifter when the buffer is consumed: buffered word or idle fill
  assign tx_next = txfull ? txbuf : IDLE_FILL;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // next state and buffer-consume strobe; cs_n release beats a same-cycle sclk edge
  always_comb begin
    state_d = state_q;
    consume = 1'b0;
    case (state_q)
      ST_IDLE: if (cs_fall) begin
        state_d = ST_ACTIVE;
        consume = 1'b1;
      end
      ST_ACTIVE: begin
        if (cs_rise)                         state_d = ST_IDLE;
        else if (sclk_fall && reload_pend)   consume = 1'b1;
      end
    endcase
  end

  // tx buffer: a load is accepted only when empty, even in the cycle it is being consumed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txfull <= 1'b0;
      txbuf  <= '0;
    end else begin
      if (consume) txfull <= 1'b0;
      if (tx_load && !txfull) begin
        txbuf  <= tx_data;
        txfull <= 1'b1;
      end
    end
  end

  // shift datapath: sample on rise, present next bit on fall, reload after a full word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_shift    <= IDLE_FILL;
      bit_cnt     <= '0;
      reload_pend <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state_q == ST_IDLE) begin
        bit_cnt     <= '0;
        reload_pend <= 1'b0;
        if (consume) tx_shift <= tx_next;
      end else if (cs_rise) begin
        bit_cnt     <= '0;
        reload_pend <= 1'b0;
      end else if (sclk_rise) begin
        rx_shift <= {rx_shift[BITS-2:0], mosi_s};
        if (bit_cnt == CW'(BITS-1)) begin
          rx_data     <= {rx_shift[BITS-2:0], mosi_s};
          rx_valid    <= 1'b1;
          bit_cnt     <= '0;
          reload_pend <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
        end
      end else if (sclk_fall) begin
        if (reload_pend) begin
          tx_shift    <= tx_next;
          reload_pend <= 1'b0;
        end else begin
          tx_shift <= {tx_shift[BITS-2:0], 1'b0};
        end
      end
    end
  end

  assign miso          = (state_q == ST_ACTIVE) ? tx_shift[BITS-1] : 1'b1;
  assign tx_ready      = ~txfull;
  assign sclk_pos_edge = sclk_rise & (state_q == ST_ACTIVE);
  assign sclk_neg_edge = sclk_fall & (state_q == ST_ACTIVE);
endmodule
